clk_time_core: RTL and testbench
================================

CLK_TIME_CORE -- requirements
Module: clk_time_core

Interface
REQ-001 The block SHALL have parameter SEC_LIMIT, default 60, meaning the seconds field modulus.
REQ-002 The block SHALL have parameter MIN_LIMIT, default 60, meaning the minutes field modulus.
REQ-003 The block SHALL have parameter HOUR_LIMIT, default 24, meaning the hours field modulus.
REQ-004 The block SHALL have parameter DW, default 6, meaning the width of every field output.
REQ-005 The block SHALL have parameter TICK_DIV, default 2, meaning the number of i_tick strobes per second advance (TICK_DIV=1: every strobe).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-008 The block SHALL have port i_tick, input, 1 bit, a one-cycle timebase strobe.
REQ-009 The block SHALL have port i_mode, input, 1 bit, a one-cycle pulse that advances the mode.
REQ-010 The block SHALL have ports i_add and i_sub, inputs, 1 bit each, one-cycle pulses that step the selected field.
REQ-011 The block SHALL have ports o_sec, o_min and o_hour, outputs, DW bits each, the field values.
REQ-012 The block SHALL have port o_mode, output, 2 bits: RUN=0, SET_HOUR=1, SET_MIN=2.
REQ-013 The block SHALL have port o_day_ovf, output, 1 bit, a one-cycle pulse on the hour-field wrap.

Function
REQ-014 FSM transitions on i_mode SHALL be: RUN->SET_HOUR->SET_MIN->RUN; without i_mode the state is held.
REQ-015 In RUN, a prescaler SHALL count i_tick strobes 0..TICK_DIV-1; when i_tick arrives with prescaler = TICK_DIV-1, the prescaler returns to 0 and seconds advance.
REQ-016 Seconds advance SHALL be +1 modulo SEC_LIMIT; a wrap (SEC_LIMIT-1->0) SHALL advance minutes in the same clock edge.
REQ-017 Minute wrap SHALL advance hours in the same edge; hour wrap (HOUR_LIMIT-1->0) SHALL make o_day_ovf high for exactly the following cycle, registered.
REQ-018 All field updates SHALL be visible one clock after the qualifying input edge; 23:59:59 SHALL go to 00:00:00 in one edge.
REQ-019 In SET_HOUR and SET_MIN, i_tick SHALL be ignored, the prescaler SHALL be held at 0, and no carries SHALL occur.
REQ-020 In a SET state, i_add SHALL step the selected field +1 with wrap LIMIT-1->0 and i_sub SHALL step it -1 with wrap 0->LIMIT-1; the other fields are unaffected.
REQ-021 i_add and i_sub in the same cycle SHALL cause no change.
REQ-022 i_add and i_sub in RUN SHALL be ignored.
REQ-023 i_mode in the same cycle as i_add or i_sub SHALL change mode only; the step is dropped.
REQ-024 The SET_MIN->RUN transition SHALL clear seconds and the prescaler to 0.
REQ-025 o_day_ovf SHALL never assert from a SET-mode step.
REQ-026 Parameters SHALL satisfy 2 <= each LIMIT <= 2^DW and TICK_DIV >= 1; an elaboration-time check SHALL reject violations.

Reset
REQ-027 While rst=0, the block SHALL asynchronously force the fields to 0, the prescaler to 0, mode to RUN and o_day_ovf to 0.
REQ-028 Reset assertion mid-operation, including in a SET state or on a wrap edge, SHALL take priority over every other input.
REQ-029 The first prescaler count after reset release SHALL occur on the first clk edge with i_tick=1.

Structure
REQ-030 Package clk_time_pkg SHALL hold the mode enum (RUN, SET_HOUR, SET_MIN) and the default limit constants.
REQ-031 Sub-module clk_mod_counter SHALL be instantiated three times, with:
- parameters LIMIT and DW;
- inputs i_inc, i_dec and i_clr;
- outputs o_count and combinational o_wrap = i_inc & (count == LIMIT-1).
REQ-032 The FSM, prescaler and o_day_ovf register SHALL reside in clk_time_core.

Verification
REQ-033 The bench SHALL cover: reset, then 4 i_tick strobes with TICK_DIV=2 -> o_sec=2, o_min=0, o_hour=0.
REQ-034 The bench SHALL cover: preset 23:59:59, then the qualifying i_tick -> 00:00:00 next cycle and o_day_ovf high for exactly 1 cycle.
REQ-035 The bench SHALL cover:
- i_mode (SET_HOUR), hour=0;
- i_sub -> hour=23;
- i_add twice -> hour=1;
- i_tick strobes -> no change.
REQ-036 The bench SHALL cover:
- SET_MIN, min=59;
- i_add -> min=0 with hour unchanged;
- i_add and i_sub together -> unchanged;
- i_mode together with i_add -> RUN, min unchanged, sec=0.
REQ-037 The bench SHALL cover: rst asserted mid-cycle in SET_MIN at 12:34:56 -> immediate 00:00:00, o_mode=RUN, o_day_ovf=0.
REQ-038 The bench SHALL cover: TICK_DIV=1, SEC_LIMIT=10, DW=4, 10 strobes -> o_sec=0, o_min=1.

Source files
------------

// File: rtl/clk_time_pkg.sv
// Shared definitions for the clock/time keeping core: mode encoding and
// default field limits.
package clk_time_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

    localparam int SEC_LIMIT_DEF  = 60;
    localparam int MIN_LIMIT_DEF  = 60;
    localparam int HOUR_LIMIT_DEF = 24;
    localparam int DW_DEF         = 6;
    localparam int TICK_DIV_DEF   = 2;

endpackage

// File: rtl/clk_mod_counter.sv
// Modulo-LIMIT up/down counter used for each time field. o_wrap flags an
// increment that rolls LIMIT-1 over to 0 so the caller can chain carries.
module clk_mod_counter #(
    parameter int LIMIT = 60,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_clr,
    output logic [DW-1:0] o_count,
    output logic          o_wrap
);

    localparam logic [DW-1:0] MAX_VAL = DW'(LIMIT - 1);

    logic [DW-1:0] count;

    // Clear wins; simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else if (i_inc && !i_dec) begin
            count <= (count == MAX_VAL) ? '0 : count + 1'b1;
        end else if (i_dec && !i_inc) begin
            count <= (count == '0) ? MAX_VAL : count - 1'b1;
        end
    end

    assign o_count = count;
    assign o_wrap  = i_inc & (count == MAX_VAL);

endmodule

// File: rtl/clk_time_core.sv
// Time-of-day core: prescaled seconds/minutes/hours with a small mode FSM
// for manually setting hours and minutes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | time advances from i_tick; i_add/i_sub ignored
// SET_HOUR | i_add/i_sub step hours; ticks ignored, prescaler held at 0
// SET_MIN  | i_add/i_sub step minutes; leaving clears seconds/prescaler
module clk_time_core
    import clk_time_pkg::*;
#(
    parameter int SEC_LIMIT  = SEC_LIMIT_DEF,
    parameter int MIN_LIMIT  = MIN_LIMIT_DEF,
    parameter int HOUR_LIMIT = HOUR_LIMIT_DEF,
    parameter int DW         = DW_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_mode,
    input  logic          i_add,
    input  logic          i_sub,
    output logic [DW-1:0] o_sec,
    output logic [DW-1:0] o_min,
    output logic [DW-1:0] o_hour,
    output logic [1:0]    o_mode,
    output logic          o_day_ovf
);

    if ((SEC_LIMIT < 2) || (SEC_LIMIT > (1 << DW)) ||
        (MIN_LIMIT < 2) || (MIN_LIMIT > (1 << DW)) ||
        (HOUR_LIMIT < 2) || (HOUR_LIMIT > (1 << DW)) ||
        (TICK_DIV < 1)) begin : g_param_check
        $error("clk_time_core: limits must be in [2, 2**DW] and TICK_DIV >= 1");
    end

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    mode_e         state;
    mode_e         state_nxt;
    logic [PW-1:0] pre;
    logic          in_run;
    logic          step_ok;
    logic          sec_inc;
    logic          sec_clr;
    logic          min_inc;
    logic          min_dec;
    logic          hour_inc;
    logic          hour_dec;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_wrap;

    // Mode state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next mode plus the per-field step/carry controls.
    always_comb begin
        state_nxt = state;
        in_run    = (state == RUN);
        step_ok   = 1'b0;
        sec_inc   = 1'b0;
        sec_clr   = 1'b0;
        min_inc   = 1'b0;
        min_dec   = 1'b0;
        hour_inc  = 1'b0;
        hour_dec  = 1'b0;

        if (i_mode) begin
            case (state)
                RUN:      state_nxt = SET_HOUR;
                SET_HOUR: state_nxt = SET_MIN;
                SET_MIN:  state_nxt = RUN;
                default:  state_nxt = RUN;
            endcase
        end

        // A mode pulse swallows any step arriving with it.
        step_ok = !in_run && !i_mode && (i_add ^ i_sub);

        sec_inc  = in_run && i_tick && (pre == PRE_MAX);
        sec_clr  = (state == SET_MIN) && i_mode;
        min_inc  = (in_run && sec_wrap) || ((state == SET_MIN) && step_ok && i_add);
        min_dec  = (state == SET_MIN) && step_ok && i_sub;
        hour_inc = (in_run && min_wrap) || ((state == SET_HOUR) && step_ok && i_add);
        hour_dec = (state == SET_HOUR) && step_ok && i_sub;
    end

    // Tick prescaler; parked at 0 outside RUN so a fresh RUN starts a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (!in_run) begin
            pre <= '0;
        end else if (i_tick) begin
            pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
        end
    end

    // Day rollover pulse, only from a running carry, never from a manual step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_day_ovf <= 1'b0;
        end else begin
            o_day_ovf <= in_run && hour_wrap;
        end
    end

    clk_mod_counter #(.LIMIT(SEC_LIMIT), .DW(DW)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (sec_inc),
        .i_dec   (1'b0),
        .i_clr   (sec_clr),
        .o_count (o_sec),
        .o_wrap  (sec_wrap)
    );

    clk_mod_counter #(.LIMIT(MIN_LIMIT), .DW(DW)) u_min (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (min_inc),
        .i_dec   (min_dec),
        .i_clr   (1'b0),
        .o_count (o_min),
        .o_wrap  (min_wrap)
    );

    clk_mod_counter #(.LIMIT(HOUR_LIMIT), .DW(DW)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (hour_inc),
        .i_dec   (hour_dec),
        .i_clr   (1'b0),
        .o_count (o_hour),
        .o_wrap  (hour_wrap)
    );

    assign o_mode = state;

endmodule

// File: tb/tb_clk_time_core.sv
// Bench for clk_time_core: directed scenarios plus random traffic, all
// compared against a seconds-of-day reference model.
module tb_clk_time_core;

    localparam int TD      = 2;
    localparam int DAY_SEC = 24 * 60 * 60;

    logic       clk;
    logic       rst;
    logic       tick, mode, add, sub;
    logic [5:0] sec_a, min_a, hour_a;
    logic [1:0] mode_a;
    logic       ovf_a;

    logic       b_tick;
    logic       b_zero;
    logic [3:0] sec_b, min_b, hour_b;
    logic [1:0] mode_b;
    logic       ovf_b;

    int n_chk;
    int n_err;

    // reference state: time as seconds of day, mode 0/1/2, prescaler, ovf pulse
    int m_t, m_mode, m_pre, m_ovf;

    clk_time_core dut_a (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (tick),
        .i_mode    (mode),
        .i_add     (add),
        .i_sub     (sub),
        .o_sec     (sec_a),
        .o_min     (min_a),
        .o_hour    (hour_a),
        .o_mode    (mode_a),
        .o_day_ovf (ovf_a)
    );

    clk_time_core #(
        .SEC_LIMIT  (10),
        .MIN_LIMIT  (10),
        .HOUR_LIMIT (10),
        .DW         (4),
        .TICK_DIV   (1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (b_tick),
        .i_mode    (b_zero),
        .i_add     (b_zero),
        .i_sub     (b_zero),
        .o_sec     (sec_b),
        .o_min     (min_b),
        .o_hour    (hour_b),
        .o_mode    (mode_b),
        .o_day_ovf (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic t, input logic md, input logic a, input logic s);
        int h, mi, se, d;
        m_ovf = 0;
        if (m_mode == 0) begin
            if (t) begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    m_t   = m_t + 1;
                    if (m_t == DAY_SEC) begin
                        m_t   = 0;
                        m_ovf = 1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (md) m_mode = 1;
        end else begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            se = m_t % 60;
            m_pre = 0;
            if (!md && (a != s)) begin
                d = a ? 1 : -1;
                if (m_mode == 1) h = (h + d + 24) % 24;
                else             mi = (mi + d + 60) % 60;
            end
            if (md) begin
                if (m_mode == 2) begin
                    se     = 0;
                    m_mode = 0;
                end else begin
                    m_mode = 2;
                end
            end
            m_t = h * 3600 + mi * 60 + se;
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":sec"},  int'(sec_a),  m_t % 60);
        chk({where, ":min"},  int'(min_a),  (m_t / 60) % 60);
        chk({where, ":hour"}, int'(hour_a), m_t / 3600);
        chk({where, ":mode"}, int'(mode_a), m_mode);
        chk({where, ":ovf"},  int'(ovf_a),  m_ovf);
    endtask

    task automatic step(input logic t, input logic md, input logic a, input logic s, input logic bt);
        @(negedge clk);
        tick = t; mode = md; add = a; sub = s; b_tick = bt;
        @(posedge clk);
        model_edge(t, md, a, s);
        #1;
        check_all("cyc");
        tick = 0; mode = 0; add = 0; sub = 0; b_tick = 0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        m_t = 0; m_mode = 0; m_pre = 0; m_ovf = 0;
        tick = 0; mode = 0; add = 0; sub = 0; b_tick = 0; b_zero = 0;
        rst = 1'b0;
        #2;
        check_all("reset");
        chk("reset_b_sec", int'(sec_b), 0);
        @(negedge clk);
        rst = 1'b1;

        // small config: every strobe counts, 10 seconds -> one minute
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
        chk("div1_sec",  int'(sec_b),  0);
        chk("div1_min",  int'(min_b),  1);
        chk("div1_hour", int'(hour_b), 0);

        // four strobes at TICK_DIV=2 -> two seconds
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        chk("run4_sec",  int'(sec_a),  2);
        chk("run4_min",  int'(min_a),  0);
        chk("run4_hour", int'(hour_a), 0);

        // hour setting
        step(0, 1, 0, 0, 0);
        chk("sethr_mode", int'(mode_a), 1);
        chk("sethr_hour", int'(hour_a), 0);
        step(0, 0, 0, 1, 0);
        chk("sethr_sub", int'(hour_a), 23);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("sethr_add2", int'(hour_a), 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        chk("sethr_tick_hour", int'(hour_a), 1);
        chk("sethr_tick_sec",  int'(sec_a),  2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // minute setting
        step(0, 1, 0, 0, 0);
        chk("setmin_mode", int'(mode_a), 2);
        step(0, 0, 0, 1, 0);
        chk("setmin_sub", int'(min_a), 59);
        step(0, 0, 1, 0, 0);
        chk("setmin_wrap_min",  int'(min_a),  0);
        chk("setmin_wrap_hour", int'(hour_a), 23);
        chk("setmin_wrap_ovf",  int'(ovf_a),  0);
        step(0, 0, 1, 1, 0);
        chk("setmin_both", int'(min_a), 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        chk("exit_mode", int'(mode_a), 0);
        chk("exit_min",  int'(min_a),  59);
        chk("exit_sec",  int'(sec_a),  0);

        // run to 23:59:59 and roll the day
        for (int i = 0; i < 118; i++) step(1, 0, 0, 0, 0);
        chk("pre_sec",  int'(sec_a),  59);
        chk("pre_hour", int'(hour_a), 23);
        step(1, 0, 0, 0, 0);
        chk("half_sec", int'(sec_a), 59);
        step(1, 0, 0, 0, 0);
        chk("roll_sec",  int'(sec_a),  0);
        chk("roll_min",  int'(min_a),  0);
        chk("roll_hour", int'(hour_a), 0);
        chk("roll_ovf",  int'(ovf_a),  1);
        step(0, 0, 0, 0, 0);
        chk("roll_ovf_off", int'(ovf_a), 0);

        // reach 12:34:56 in SET_MIN, then async reset between edges
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 112; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("prerst_hour", int'(hour_a), 12);
        chk("prerst_min",  int'(min_a),  34);
        chk("prerst_sec",  int'(sec_a),  56);
        chk("prerst_mode", int'(mode_a), 2);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        m_t = 0; m_mode = 0; m_pre = 0; m_ovf = 0;
        chk("rst_sec",  int'(sec_a),  0);
        chk("rst_min",  int'(min_a),  0);
        chk("rst_hour", int'(hour_a), 0);
        chk("rst_mode", int'(mode_a), 0);
        chk("rst_ovf",  int'(ovf_a),  0);
        @(negedge clk);
        rst = 1'b1;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(1)),
                 logic'($urandom_range(15) == 0),
                 logic'($urandom_range(3) == 0),
                 logic'($urandom_range(3) == 0),
                 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
